// File: rtl/bsg_core_intf_trace_rom.sv
// bsg_core_intf_trace_rom: per-core trace programs for the core-interface trace replay.
// Each send entry is followed by its receive/compare entry, and a done entry ends the program.
// Addresses past the done entry also read as done, so the replay halts safely.
// Optional sticky out-of-bounds flag: define TRACE_ROM_BOUNDS_CHECK_EN.
module bsg_core_intf_trace_rom #(
  parameter int unsigned width_p      = 74,
  parameter int unsigned addr_width_p = 15,
  parameter int unsigned core_id_p    = 0
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o,
  output logic                    oob_o
);

  localparam int unsigned entry_width_lp = 74;
  localparam int unsigned last_idx_lp    = (core_id_p == 0) ? 6 : 4;

  localparam logic [3:0] op_send_lp = 4'b0000;
  localparam logic [3:0] op_recv_lp = 4'b0001;
  localparam logic [3:0] op_done_lp = 4'b0010;

  localparam logic [73:0] done_entry_lp = {op_done_lp, 70'b0};

  // Reject unsupported configurations at elaboration
  if (width_p != entry_width_lp) begin : g_bad_width
    $error("bsg_core_intf_trace_rom: width_p must be 74");
  end
  if (core_id_p > 2) begin : g_bad_core
    $error("bsg_core_intf_trace_rom: core_id_p must be 0, 1 or 2");
  end

  // Send: packet right-aligned as {lr, sc, we, addr, wdata}; top payload bits zero
  function automatic logic [73:0] send_entry(input logic we, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    return {op_send_lp, 3'b000, 1'b0, 1'b0, we, addr, wdata};
  endfunction

  // Receive: expected read data zero-extended to the payload width
  function automatic logic [73:0] recv_entry(input logic [31:0] rdata);
    return {op_recv_lp, 38'b0, rdata};
  endfunction

  logic [73:0] entry;

  // Combinational ROM lookup, independent of clock and reset
  always_comb begin
    entry = done_entry_lp;
    if (core_id_p == 0) begin
      case (addr_i)
        addr_width_p'(0): entry = send_entry(1'b1, 32'h0000_0100, 32'hA0A0_0001);
        addr_width_p'(1): entry = recv_entry(32'hA0A0_0001);
        addr_width_p'(2): entry = send_entry(1'b0, 32'h0000_0100, 32'h0000_0000);
        addr_width_p'(3): entry = recv_entry(32'hA0A0_0001);
        addr_width_p'(4): entry = send_entry(1'b1, 32'h0000_0140, 32'h0000_00C0);
        addr_width_p'(5): entry = recv_entry(32'h0000_00C0);
        default:          entry = done_entry_lp;
      endcase
    end else if (core_id_p == 1) begin
      case (addr_i)
        addr_width_p'(0): entry = send_entry(1'b1, 32'h0000_0200, 32'hB1B1_0002);
        addr_width_p'(1): entry = recv_entry(32'hB1B1_0002);
        addr_width_p'(2): entry = send_entry(1'b0, 32'h0000_0200, 32'h0000_0000);
        addr_width_p'(3): entry = recv_entry(32'hB1B1_0002);
        default:          entry = done_entry_lp;
      endcase
    end else begin
      case (addr_i)
        addr_width_p'(0): entry = send_entry(1'b1, 32'h0000_0300, 32'hC2C2_0003);
        addr_width_p'(1): entry = recv_entry(32'hC2C2_0003);
        addr_width_p'(2): entry = send_entry(1'b0, 32'h0000_0300, 32'h0000_0000);
        addr_width_p'(3): entry = recv_entry(32'hC2C2_0003);
        default:          entry = done_entry_lp;
      endcase
    end
  end

  assign data_o = width_p'(entry);

`ifdef TRACE_ROM_BOUNDS_CHECK_EN
  logic past_end;
  logic oob_r;

  assign past_end = (addr_i > addr_width_p'(last_idx_lp));

  // Sticky out-of-bounds flag; reset wins over a same-cycle detection
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      oob_r <= 1'b0;
    end else if (past_end) begin
      oob_r <= 1'b1;
`ifndef SYNTHESIS
      if (!oob_r) $error("bsg_core_intf_trace_rom: address past end of trace program");
`endif
    end
  end

  assign oob_o = oob_r;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk_i & nreset_i;
  assign oob_o          = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_core_intf_trace_rom.sv
// tb_bsg_core_intf_trace_rom: scoreboard bench for the three trace programs.
// Expected words come from an operation-list model (store/load per op, memory map for loads).
module tb_bsg_core_intf_trace_rom;

  localparam int unsigned addr_width_lp = 15;
  localparam logic [73:0] done_w = {4'b0010, 70'b0};

  typedef struct {
    bit        we;
    bit [31:0] a;
    bit [31:0] d;
  } op_t;

  typedef struct {
    logic [73:0] d0;
    logic [73:0] d1;
    logic [73:0] d2;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  logic [addr_width_lp-1:0] addr0, addr1, addr2;
  logic [73:0] data0, data1, data2;
  logic oob0, oob1, oob2;

  always #5 clk = ~clk;

  bsg_core_intf_trace_rom #(.width_p(74), .addr_width_p(addr_width_lp), .core_id_p(0)) dut0 (
    .clk_i(clk), .nreset_i(nreset), .addr_i(addr0), .data_o(data0), .oob_o(oob0));
  bsg_core_intf_trace_rom #(.width_p(74), .addr_width_p(addr_width_lp), .core_id_p(1)) dut1 (
    .clk_i(clk), .nreset_i(nreset), .addr_i(addr1), .data_o(data1), .oob_o(oob1));
  bsg_core_intf_trace_rom #(.width_p(74), .addr_width_p(addr_width_lp), .core_id_p(2)) dut2 (
    .clk_i(clk), .nreset_i(nreset), .addr_i(addr2), .data_o(data2), .oob_o(oob2));

  logic [73:0] prog [3][16];
  int unsigned last_idx [3];
  exp_t sb [$];
  logic [2:0] oob_m = 3'b000;
  bit mon_en = 1'b0;
  int checks = 0;
  int passed = 0;

  function automatic op_t mk(bit we, bit [31:0] a, bit [31:0] d);
    op_t o;
    o.we = we;
    o.a  = a;
    o.d  = d;
    return o;
  endfunction

  // Expand an operation list: each op becomes a send then its expected receive
  task automatic build(input int c, input op_t ops[$]);
    bit [31:0] mem [bit [31:0]];
    int n;
    bit [31:0] rd;
    n = 0;
    foreach (ops[k]) begin
      prog[c][n] = {4'd0, 3'd0, 1'b0, 1'b0, ops[k].we, ops[k].a, ops[k].we ? ops[k].d : 32'd0};
      n = n + 1;
      if (ops[k].we) mem[ops[k].a] = ops[k].d;
      rd = mem.exists(ops[k].a) ? mem[ops[k].a] : 32'd0;
      prog[c][n] = {4'd1, 38'd0, rd};
      n = n + 1;
    end
    prog[c][n] = done_w;
    last_idx[c] = n;
  endtask

  function automatic logic [73:0] ref_data(int c, int unsigned a);
    if (a > last_idx[c]) return done_w;
    return prog[c][a];
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply addresses after the edge and queue the words they should read
  task automatic drive_exp(input int unsigned a0, input int unsigned a1, input int unsigned a2,
                           input logic rn, input logic [73:0] e0, input logic [73:0] e1,
                           input logic [73:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    nreset = rn;
    addr0  = addr_width_lp'(a0);
    addr1  = addr_width_lp'(a1);
    addr2  = addr_width_lp'(a2);
    e.d0 = e0;
    e.d1 = e1;
    e.d2 = e2;
    sb.push_back(e);
  endtask

  task automatic drive(input int unsigned a0, input int unsigned a1, input int unsigned a2,
                       input logic rn);
    drive_exp(a0, a1, a2, rn, ref_data(0, a0), ref_data(1, a1), ref_data(2, a2));
  endtask

  function automatic int unsigned rnd_addr();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 32767);
    return $urandom_range(0, 9);
  endfunction

`ifdef TRACE_ROM_BOUNDS_CHECK_EN
  // Sticky flag model: any edge with reset released and an address past the done entry
  always @(posedge clk) begin
    if (!nreset) oob_m <= 3'b000;
    else begin
      if (addr0 > last_idx[0]) oob_m[0] <= 1'b1;
      if (addr1 > last_idx[1]) oob_m[1] <= 1'b1;
      if (addr2 > last_idx[2]) oob_m[2] <= 1'b1;
    end
  end
`endif

  // Monitor: compare outputs on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data_core0", data0, e.d0);
          chk("data_core1", data1, e.d1);
          chk("data_core2", data2, e.d2);
        end
        chk("oob_core0", 74'(oob0), 74'(oob_m[0]));
        chk("oob_core1", 74'(oob1), 74'(oob_m[1]));
        chk("oob_core2", 74'(oob2), 74'(oob_m[2]));
      end
    end
  end

  initial begin
    op_t ops [$];
    ops = {};
    ops.push_back(mk(1'b1, 32'h100, 32'hA0A0_0001));
    ops.push_back(mk(1'b0, 32'h100, 32'h0));
    ops.push_back(mk(1'b1, 32'h140, 32'h0000_00C0));
    build(0, ops);
    ops = {};
    ops.push_back(mk(1'b1, 32'h200, 32'hB1B1_0002));
    ops.push_back(mk(1'b0, 32'h200, 32'h0));
    build(1, ops);
    ops = {};
    ops.push_back(mk(1'b1, 32'h300, 32'hC2C2_0003));
    ops.push_back(mk(1'b0, 32'h300, 32'h0));
    build(2, ops);

    nreset = 1'b0;
    addr0  = '0;
    addr1  = '0;
    addr2  = '0;
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b1;
    mon_en = 1'b1;

    // Literal words for the headline entries
    drive_exp(0, 3, 4, 1'b1,
              {4'b0000, 3'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hA0A0_0001},
              {4'b0001, 38'b0, 32'hB1B1_0002},
              {4'b0010, 70'b0});
    drive_exp(6, 4, 5, 1'b1, {4'b0010, 70'b0}, {4'b0010, 70'b0}, {4'b0010, 70'b0});

    // Walk every programmed entry plus a few past the end
    for (int i = 0; i < 10; i++) drive(i, i, i, 1'b1);

    // Random addresses, mostly near the programs
    for (int i = 0; i < 400; i++) drive(rnd_addr(), rnd_addr(), rnd_addr(), 1'b1);

    // Reset pulse with out-of-bounds addresses, then in-range addresses
    drive(20, 20, 20, 1'b0);
    drive(0, 0, 0, 1'b1);
    drive(1, 2, 3, 1'b1);

    // Full sweep of the address space
    for (int i = 0; i < 32768; i++) drive(i, i, i, 1'b1);

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bsg_core_intf_trace_rom.md
BSG_CORE_INTF_TRACE_ROM -- requirements
Module: bsg_core_intf_trace_rom

Interface
REQ-001 Parameter width_p, default 74, is the entry width: 4-bit opcode plus 70-bit payload; any other value SHALL be an elaboration error.
REQ-002 Parameter addr_width_p, default 15, is the ROM address width.
REQ-003 Parameter core_id_p, default 0, selects the trace program (0, 1 or 2); any other value SHALL be an elaboration error.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 nreset_i  input  1  reset, synchronous, active-low.
REQ-006 addr_i  input  addr_width_p  entry index, from the trace-replay rom_addr_o.
REQ-007 data_o  output  width_p  entry at addr_i; bits [73:70] are the opcode, bits [69:0] are the payload.
REQ-008 oob_o  output  1  sticky flag: an address past the program's final entry was presented.

Function
REQ-009 data_o SHALL be purely combinational from addr_i and SHALL be valid in the same cycle, with zero latency and no dependence on clk_i or nreset_i.
REQ-010 Opcodes SHALL be: 4'b0000 send; 4'b0001 receive/compare; 4'b0010 done.
REQ-011 Send payload SHALL carry the core-cache packet right-aligned as {lr[66], sc[65], we[64], addr[63:32], wdata[31:0]}; payload bits [69:67] SHALL be 0.
REQ-012 Receive payload SHALL be {38'b0, expected_rdata[31:0]}, matching the zero-extended cache read data.
REQ-013 Every send SHALL be followed by exactly one receive; for a store, expected_rdata SHALL equal the written wdata.
REQ-014 core_id_p=0 SHALL hold, at entries 0..6:
  - send SW 0x100/0xA0A0_0001; recv 0xA0A0_0001
  - send LW 0x100; recv 0xA0A0_0001
  - send SW 0x140/0x0000_00C0; recv 0x0000_00C0
  - done
REQ-015 core_id_p=1 SHALL hold, at entries 0..4:
  - send SW 0x200/0xB1B1_0002; recv 0xB1B1_0002
  - send LW 0x200; recv 0xB1B1_0002
  - done
REQ-016 core_id_p=2 SHALL hold, at entries 0..4:
  - send SW 0x300/0xC2C2_0003; recv 0xC2C2_0003
  - send LW 0x300; recv 0xC2C2_0003
  - done
REQ-017 The programs SHALL use disjoint block addresses, so the outcome is independent of inter-core ordering.
REQ-018 Any addr_i beyond the last programmed entry, up to 2^addr_width_p-1, SHALL return {4'b0010, 70'b0}, so the replay halts safely.
REQ-019 The final programmed entry (the done entry) SHALL NOT count as out of bounds.

Reset
REQ-020 While nreset_i is sampled low, oob_o SHALL be 0 at the next rising edge.
REQ-021 Reset SHALL have no effect on data_o.
REQ-022 A reset asserted in the same cycle as an out-of-bounds address SHALL win, leaving oob_o at 0.

Configuration
REQ-023 With macro TRACE_ROM_BOUNDS_CHECK_EN defined: on each rising edge with nreset_i high and addr_i greater than the last programmed index, oob_o SHALL be set to 1 and SHALL stay set until reset.
REQ-024 With TRACE_ROM_BOUNDS_CHECK_EN defined, the first out-of-bounds detection SHALL also issue one simulation $error.
REQ-025 Without TRACE_ROM_BOUNDS_CHECK_EN, oob_o SHALL be tied to 0 and no flop SHALL be inferred.

Verification
REQ-026 core_id_p=0, addr_i=0 -> data_o = {4'b0000, 3'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hA0A0_0001}, in the same cycle.
REQ-027 core_id_p=1, addr_i=3 -> data_o = {4'b0001, 38'b0, 32'hB1B1_0002}.
REQ-028 core_id_p=2: addr_i=4 -> {4'b0010, 70'b0} with oob_o staying 0; then addr_i=5 -> the same done word, and oob_o goes to 1 one edge later (macro defined).
REQ-029 Macro defined, with oob_o=1: drive nreset_i low for 1 edge -> oob_o=0; then addr_i=0 -> oob_o stays 0.
REQ-030 Macro undefined: sweep addr_i over 0..32767 -> oob_o constantly 0, and every index past the program returns the done word.
REQ-031 Full system run with 2 caches using programs 0 and 1 -> both replay done_o assert with no compare error.
